// File: rtl/tt_accum_alu_if.sv
// rtl/tt_accum_alu_if.sv - operand/result valid-ready bundle for tt_accum_alu
interface tt_accum_alu_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic [WIDTH-1:0] acc_value;

  modport master (
    output in_valid, op_a, op_b, mode, out_ready,
    input  in_ready, out_valid, result, carry, acc_value
  );

  modport slave (
    input  in_valid, op_a, op_b, mode, out_ready,
    output in_ready, out_valid, result, carry, acc_value
  );
endinterface

// File: rtl/tt_accum_alu.sv
// rtl/tt_accum_alu.sv - registered add/sub/accumulate/load ALU with valid-ready handshake
module tt_accum_alu #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  tt_accum_alu_if.slave  bus
);
  localparam logic [1:0] MODE_ADD  = 2'b00;
  localparam logic [1:0] MODE_SUB  = 2'b01;
  localparam logic [1:0] MODE_ACC  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready;
  logic             accept;
  logic [WIDTH:0]   raw;
  logic [WIDTH-1:0] clamped;

  assign in_ready = ena & (~out_valid_q | bus.out_ready);
  assign accept   = bus.in_valid & in_ready;

  // Bit WIDTH of raw is carry-out for ADD/ACC and borrow for SUB.
  always_comb begin
    raw = '0;
    case (bus.mode)
      MODE_ADD:  raw = {1'b0, bus.op_a} + {1'b0, bus.op_b};
      MODE_SUB:  raw = {1'b0, bus.op_a} - {1'b0, bus.op_b};
      MODE_ACC:  raw = {1'b0, acc_q} + {1'b0, bus.op_a};
      MODE_LOAD: raw = {1'b0, bus.op_a};
      default:   raw = '0;
    endcase
    clamped = raw[WIDTH-1:0];
    if (SATURATE && raw[WIDTH]) begin
      clamped = (bus.mode == MODE_SUB) ? '0 : '1;
    end
  end

  always_comb begin
    result_d    = result_q;
    carry_d     = carry_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      result_d    = clamped;
      carry_d     = raw[WIDTH];
      out_valid_d = 1'b1;
      if (bus.mode == MODE_ACC || bus.mode == MODE_LOAD) begin
        acc_d = clamped;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      carry_q     <= 1'b0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      carry_q     <= carry_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.carry     = carry_q;
  assign bus.acc_value = acc_q;
endmodule

// File: tb/tb_tt_accum_alu.sv
// tb/tb_tt_accum_alu.sv - bench for tt_accum_alu, wrapping and saturating instances side by side
module tb_tt_accum_alu;
  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ACC = 2'b10, LOAD = 2'b11;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       in_valid;
  logic [1:0] mode;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       out_ready;
  logic       mon_en;
  logic       exp_rdy;

  int total = 0;
  int bad   = 0;

  // Entry layout: {acc[7:0], carry, result[7:0]}
  logic [16:0] q0[$];
  logic [16:0] q1[$];
  logic [16:0] e0, e1, t0, t1;
  logic [7:0]  m_acc0, m_acc1;

  tt_accum_alu_if #(.WIDTH(8)) b0 ();
  tt_accum_alu_if #(.WIDTH(8)) b1 ();

  assign b0.in_valid  = in_valid;
  assign b0.mode      = mode;
  assign b0.op_a      = op_a;
  assign b0.op_b      = op_b;
  assign b0.out_ready = out_ready;
  assign b1.in_valid  = in_valid;
  assign b1.mode      = mode;
  assign b1.op_a      = op_a;
  assign b1.op_b      = op_b;
  assign b1.out_ready = out_ready;

  tt_accum_alu #(.WIDTH(8), .SATURATE(1'b0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (b0.slave)
  );

  tt_accum_alu #(.WIDTH(8), .SATURATE(1'b1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (b1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] model(input bit sat, input logic [1:0] m,
                                        input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] acc);
    logic [8:0] s;
    logic [7:0] r;
    logic [7:0] nacc;
    logic       c;
    s    = '0;
    nacc = acc;
    case (m)
      ADD: begin
        s = {1'b0, a} + {1'b0, b};
        c = s[8];
        r = (sat && c) ? 8'hFF : s[7:0];
      end
      SUB: begin
        c = (a < b);
        r = (sat && c) ? 8'h00 : a - b;
      end
      ACC: begin
        s    = {1'b0, acc} + {1'b0, a};
        c    = s[8];
        r    = (sat && c) ? 8'hFF : s[7:0];
        nacc = r;
      end
      default: begin
        c    = 1'b0;
        r    = a;
        nacc = a;
      end
    endcase
    return {nacc, c, r};
  endfunction

  // Scoreboard: push on accept, pop on output transfer; inputs are stable at negedge.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_rdy = ena && ((q0.size() == 0) || out_ready);
      check("in_ready0", 32'(b0.in_ready), 32'(exp_rdy));
      check("in_ready1", 32'(b1.in_ready), 32'(exp_rdy));
      check("out_valid0", 32'(b0.out_valid), 32'(q0.size() != 0));
      check("out_valid1", 32'(b1.out_valid), 32'(q1.size() != 0));
      if (q0.size() != 0 && out_ready) begin
        e0 = q0.pop_front();
        check("sb_result0", 32'(b0.result), 32'(e0[7:0]));
        check("sb_carry0", 32'(b0.carry), 32'(e0[8]));
        check("sb_acc0", 32'(b0.acc_value), 32'(e0[16:9]));
      end
      if (q1.size() != 0 && out_ready) begin
        e1 = q1.pop_front();
        check("sb_result1", 32'(b1.result), 32'(e1[7:0]));
        check("sb_carry1", 32'(b1.carry), 32'(e1[8]));
        check("sb_acc1", 32'(b1.acc_value), 32'(e1[16:9]));
      end
      if (in_valid && exp_rdy) begin
        t0 = model(1'b0, mode, op_a, op_b, m_acc0);
        t1 = model(1'b1, mode, op_a, op_b, m_acc1);
        q0.push_back(t0);
        q1.push_back(t1);
        m_acc0 = t0[16:9];
        m_acc1 = t1[16:9];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    mode     = m;
    op_a     = a;
    op_b     = b;
    step();
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; mode = ADD;
    op_a = 8'h00; op_b = 8'h00; out_ready = 1'b1; mon_en = 1'b0;
    m_acc0 = 8'h00; m_acc1 = 8'h00; exp_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid0", 32'(b0.out_valid), 32'h0);
    check("rst_result0", 32'(b0.result), 32'h0);
    check("rst_acc1", 32'(b1.acc_value), 32'h0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    issue(ADD, 8'h40, 8'h30);
    check("add_r0", 32'(b0.result), 32'h70);
    check("add_c0", 32'(b0.carry), 32'h0);
    check("add_r1", 32'(b1.result), 32'h70);
    issue(ADD, 8'hF0, 8'h20);
    check("addovf_r0", 32'(b0.result), 32'h10);
    check("addovf_c0", 32'(b0.carry), 32'h1);
    check("addovf_r1", 32'(b1.result), 32'hFF);
    check("addovf_c1", 32'(b1.carry), 32'h1);

    issue(SUB, 8'h10, 8'h20);
    check("subbor_r0", 32'(b0.result), 32'hF0);
    check("subbor_c0", 32'(b0.carry), 32'h1);
    check("subbor_r1", 32'(b1.result), 32'h00);
    check("subbor_c1", 32'(b1.carry), 32'h1);
    issue(SUB, 8'h20, 8'h10);
    check("sub_r0", 32'(b0.result), 32'h10);
    check("sub_c0", 32'(b0.carry), 32'h0);

    issue(LOAD, 8'h05, 8'hAA);
    check("load_r0", 32'(b0.result), 32'h05);
    for (int i = 0; i < 3; i++) begin
      issue(ACC, 8'h03, 8'h55);
      check("acc_r0", 32'(b0.result), 32'(8'h05 + 8'h03 * (i + 1)));
    end
    check("acc_val0", 32'(b0.acc_value), 32'h0E);
    check("acc_val1", 32'(b1.acc_value), 32'h0E);
    issue(ADD, 8'h01, 8'h01);
    check("add_keeps_acc_r", 32'(b0.result), 32'h02);
    check("add_keeps_acc", 32'(b0.acc_value), 32'h0E);
    in_valid = 1'b0;
    step();
    check("drain_valid", 32'(b0.out_valid), 32'h0);

    out_ready = 1'b0;
    issue(ADD, 8'h11, 8'h22);
    check("bp_valid", 32'(b0.out_valid), 32'h1);
    check("bp_result", 32'(b0.result), 32'h33);
    mode = SUB; op_a = 8'h50; op_b = 8'h10;
    #1;
    check("bp_in_ready", 32'(b0.in_ready), 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_hold_result", 32'(b0.result), 32'h33);
      check("bp_hold_valid", 32'(b0.out_valid), 32'h1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(b0.in_ready), 32'h1);
    step();
    check("bp_swap_result", 32'(b0.result), 32'h40);
    check("bp_swap_valid", 32'(b0.out_valid), 32'h1);
    for (int i = 0; i < 8; i++) begin
      issue(2'($urandom_range(3)), 8'($urandom), 8'($urandom));
      check("stream_valid", 32'(b0.out_valid), 32'h1);
    end
    in_valid = 1'b0;
    step();
    check("stream_drain", 32'(b0.out_valid), 32'h0);

    ena = 1'b0;
    in_valid = 1'b1; mode = LOAD; op_a = 8'h77; op_b = 8'h00;
    #1;
    check("ena0_in_ready", 32'(b0.in_ready), 32'h0);
    repeat (2) step();
    check("ena0_valid", 32'(b0.out_valid), 32'h0);
    check("ena0_acc0", 32'(b0.acc_value), 32'(m_acc0));
    check("ena0_acc1", 32'(b1.acc_value), 32'(m_acc1));
    ena = 1'b1;
    step();
    check("ena1_valid", 32'(b0.out_valid), 32'h1);
    check("ena1_result", 32'(b0.result), 32'h77);
    check("ena1_acc", 32'(b0.acc_value), 32'h77);
    in_valid = 1'b0; out_ready = 1'b0; ena = 1'b0;
    step();
    check("ena0_hold", 32'(b0.out_valid), 32'h1);
    out_ready = 1'b1;
    step();
    check("ena0_consume", 32'(b0.out_valid), 32'h0);

    ena = 1'b1; out_ready = 1'b0;
    issue(LOAD, 8'h2A, 8'h00);
    in_valid = 1'b0;
    check("pre_rst_valid", 32'(b0.out_valid), 32'h1);
    check("pre_rst_acc", 32'(b0.acc_value), 32'h2A);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("arst_valid0", 32'(b0.out_valid), 32'h0);
    check("arst_result0", 32'(b0.result), 32'h0);
    check("arst_carry0", 32'(b0.carry), 32'h0);
    check("arst_acc0", 32'(b0.acc_value), 32'h0);
    check("arst_valid1", 32'(b1.out_valid), 32'h0);
    check("arst_acc1", 32'(b1.acc_value), 32'h0);
    q0.delete();
    q1.delete();
    m_acc0 = 8'h00;
    m_acc1 = 8'h00;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    mon_en    = 1'b1;
    step();
    check("post_rst_valid", 32'(b0.out_valid), 32'h0);
    check("sb_empty0", 32'(q0.size()), 32'h0);
    check("sb_empty1", 32'(q1.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
